nand4_sweep_ctrl: RTL
=====================

NAND4_SWEEP_CTRL -- requirements
Module: nand4_sweep_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, meaning wait cycles between driving a vector and sampling y; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 lo  input  4  first vector of sweep; latched on accepted start.
REQ-006 hi  input  4  last vector of sweep; latched on accepted start.
REQ-007 a_out  output  4  vector driven to the 4-input NAND datapath input a.
REQ-008 y_in  input  1  NAND datapath output y.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 ones_cnt  output  5  number of sampled vectors with y_in=1.
REQ-012 err  output  1  sticky; set when any sampled y_in differs from ~&a_out.
REQ-013 err_vec  output  4  first vector that mismatched; valid when err=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, SAMPLE and DONE.
REQ-015 IDLE + start=1 SHALL latch lo/hi, set a_out=lo, and clear ones_cnt, err and err_vec; busy SHALL be 1 from the next cycle; next state WAIT with the settle counter at SETTLE.
REQ-016 WAIT SHALL hold a_out, decrement the settle counter each cycle, and go to SAMPLE after exactly SETTLE cycles.
REQ-017 SAMPLE SHALL, at its clock edge, add y_in to ones_cnt, and if y_in != ~&a_out with err=0, set err=1 and err_vec=a_out.
REQ-018 SAMPLE with a_out==hi_latched SHALL go to DONE; otherwise it SHALL set a_out=a_out+1 (mod 16), reload the settle counter and go to WAIT.
REQ-019 Each vector SHALL take exactly SETTLE+1 cycles; N=((hi-lo) mod 16)+1 vectors; total busy cycles SHALL be N*(SETTLE+1).
REQ-020 lo>hi SHALL wrap 15->0 (e.g. lo=14,hi=1 sweeps 14,15,0,1); lo==hi SHALL sweep one vector; lo=0,hi=15 sweeps 16 vectors (ones_cnt max 16, fits 5 bits).
REQ-021 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-022 start SHALL be ignored in WAIT, SAMPLE and DONE, and changes on lo/hi SHALL be ignored during a sweep.
REQ-023 ones_cnt, err, err_vec and a_out SHALL hold their final values in IDLE until the next accepted start.
REQ-024 err SHALL stay at 1 once set, and err_vec SHALL NOT be overwritten by later mismatches in the same sweep.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force state IDLE, a_out=0, busy=0, done=0, ones_cnt=0, err=0, err_vec=0, and clear the settle counter and latched lo/hi.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; after release, the first accepted start SHALL begin a fresh sweep.

Verification (SETTLE=1, ideal NAND model unless stated)
REQ-027 lo=0, hi=15, start pulse -> busy high for 32 cycles, a_out steps 0..15, done pulse, ones_cnt=15, err=0.
REQ-028 lo=15, hi=15 -> busy 2 cycles, ones_cnt=0, err=0, done pulse.
REQ-029 lo=14, hi=1 -> vectors 14,15,0,1, busy 8 cycles, ones_cnt=3, err=0.
REQ-030 lo=0, hi=15 with y_in stuck at 1 -> ones_cnt=16, err=1, err_vec=15.
REQ-031 rst asserted while a_out=5 -> all outputs 0 asynchronously, no done; start pulsed while busy in a following sweep -> ignored, sweep length unchanged.
REQ-032 SETTLE=3, lo=0, hi=3 -> each vector held 4 cycles, busy 16 cycles, ones_cnt=4.

Source files
------------

// File: rtl/nand4_sweep_ctrl.sv
// nand4_sweep_ctrl: steps a 4-bit vector through an external 4-input NAND.
// The sweep runs from lo to hi and wraps modulo 16. Each vector is held
// for SETTLE cycles and then y is sampled. The block counts the sampled
// ones and records the first vector where y differs from the ideal NAND.
module nand4_sweep_ctrl #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] lo,
   input  logic [3:0] hi,
   output logic [3:0] a_out,
   input  logic       y_in,
   output logic       busy,
   output logic       done,
   output logic [4:0] ones_cnt,
   output logic       err,
   output logic [3:0] err_vec
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

   state_t     state_q, state_d;
   logic [3:0] a_q,     a_d;
   logic [3:0] hi_q,    hi_d;
   logic [3:0] cnt_q,   cnt_d;
   logic [4:0] ones_q,  ones_d;
   logic       err_q,   err_d;
   logic [3:0] errv_q,  errv_d;

   // State and datapath registers; reset clears everything without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
         ones_q  <= '0;
         err_q   <= 1'b0;
         errv_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         ones_q  <= ones_d;
         err_q   <= err_d;
         errv_q  <= errv_d;
      end
   end

   // Next-state logic. All results hold their values unless a state updates them.
   // lo is loaded straight into a_q, so only hi needs a separate latch.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      ones_d  = ones_q;
      err_d   = err_q;
      errv_d  = errv_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               hi_d    = hi;
               a_d     = lo;
               ones_d  = '0;
               err_d   = 1'b0;
               errv_d  = '0;
               cnt_d   = SETTLE_LD;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end
            if (cnt_q <= 4'd1) begin
               state_d = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            ones_d = ones_q + {4'b0000, y_in};
            if ((y_in != ~&a_q) && !err_q) begin
               err_d  = 1'b1;
               errv_d = a_q;
            end
            if (a_q == hi_q) begin
               state_d = S_DONE;
            end else begin
               a_d     = a_q + 4'd1;
               cnt_d   = SETTLE_LD;
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Status outputs are decoded from the state, so they follow an asynchronous reset at once.
   always_comb begin
      busy     = (state_q == S_WAIT) || (state_q == S_SAMPLE);
      done     = (state_q == S_DONE);
      a_out    = a_q;
      ones_cnt = ones_q;
      err      = err_q;
      err_vec  = errv_q;
   end

endmodule
